// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the parametrised FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Defaults matching the original 8-bit, 256-entry buffer.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Ceiling log2, usable in constant expressions at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port storage array, one write port and one
//                registered read port. The array is never reset so it maps
//                onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read port: registered, read-before-write when addresses collide, and
  // holds its value between reads.
  always_ff @(posedge clk) begin
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo
//  Description : Single-clock FIFO with parametrised width and depth, full
//                DEPTH capacity, almost-full/almost-empty thresholds, read
//                valid strobe and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [clog2(DEPTH):0]    buf_cnt,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);

  // Reject parameter sets the pointer arithmetic cannot support.
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of 2 and at least 4");
    end
    if ((AF_LEVEL < 0) || (AF_LEVEL > DEPTH) ||
        (AE_LEVEL < 0) || (AE_LEVEL > DEPTH)) begin : g_bad_levels
      $error("param_fifo: AF_LEVEL and AE_LEVEL must lie within 0..DEPTH");
    end
  endgenerate

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_rd_valid;
  logic              r_rd_seen;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [CW-1:0]     w_next_cnt;
  logic [DATA_W-1:0] w_mem_rdata;

  // Accept decisions on registered state; a full FIFO still takes a write
  // when a read frees a slot in the same cycle, but an empty FIFO never
  // forwards a same-cycle write to the reader.
  always_comb begin
    w_rd_ok    = rd_en && !r_empty;
    w_wr_ok    = wr_en && (!r_full || w_rd_ok);
    w_next_cnt = r_cnt;
    if (w_wr_ok && !w_rd_ok) w_next_cnt = r_cnt + 1'b1;
    if (w_rd_ok && !w_wr_ok) w_next_cnt = r_cnt - 1'b1;
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_ok),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .re    (w_rd_ok),
    .raddr (r_rd_ptr),
    .rdata (w_mem_rdata)
  );

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= w_next_cnt;
    end
  end

  // Status flags follow the next count so they move together with buf_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_full         <= (w_next_cnt == c_depth);
      r_empty        <= (w_next_cnt == '0);
      r_almost_full  <= (w_next_cnt >= c_af_level);
      r_almost_empty <= (w_next_cnt <= c_ae_level);
    end
  end

  // Read strobe, plus a flag that gates the unreset RAM output to zero until
  // the first real read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_seen <= 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_ok) r_overflow <= 1'b1;
      else if (clr_err)      r_overflow <= 1'b0;
      if (rd_en && !w_rd_ok) r_underflow <= 1'b1;
      else if (clr_err)      r_underflow <= 1'b0;
    end
  end

  assign data_out     = r_rd_seen ? w_mem_rdata : '0;
  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign buf_cnt      = r_cnt;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fifo
//  Description : Directed self-checking bench for param_fifo, DEPTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [2:0]    buf_cnt;

  int total = 0;
  int bad   = 0;

  param_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .buf_cnt      (buf_cnt),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", buf_cnt); end
    total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin bad++; $display("FAIL reset_flags: got e/ae/f/af=%b want 1100", {empty, almost_empty, full, almost_full}); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    total++; if ({rd_valid, overflow, underflow} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got v/ov/un=%b want 000", {rd_valid, overflow, underflow}); end
  endtask

  task automatic test_fill_drain;
    logic [7:0] d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [1:0] ae_exp [4] = '{2'b10, 2'b00, 2'b01, 2'b01};  // {almost_empty, almost_full}
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = d[i];
      tick();
      total++; if (buf_cnt !== 3'(i + 1)) begin bad++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, buf_cnt, i + 1); end
      total++; if ({almost_empty, almost_full} !== ae_exp[i]) begin bad++; $display("FAIL fill_thresh[%0d]: got ae/af=%b want %b", i, {almost_empty, almost_full}, ae_exp[i]); end
    end
    wr_en = 1'b0;
    total++; if ({full, empty} !== 2'b10) begin bad++; $display("FAIL fill_full: got f/e=%b want 10", {full, empty}); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rd_valid !== 1'b1 || data_out !== d[i]) begin bad++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, data_out, d[i]); end
    end
    rd_en = 1'b0;
    total++; if ({empty, full, buf_cnt} !== {2'b10, 3'd0}) begin bad++; $display("FAIL drain_empty: got e=%b f=%b cnt=%0d want e=1 f=0 cnt=0", empty, full, buf_cnt); end
    tick();
    total++; if (rd_valid !== 1'b0 || data_out !== 8'hD4) begin bad++; $display("FAIL drain_hold: got v=%b d=%h want v=0 d=d4", rd_valid, data_out); end
  endtask

  task automatic test_simul_full;
    logic [7:0] d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] e [4] = '{8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = d[i];
      tick();
    end
    rd_en = 1'b1; data_in = 8'hE5;
    tick();
    wr_en = 1'b0;
    total++; if (buf_cnt !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL simul_full: got cnt=%0d ov=%b f=%b want cnt=4 ov=0 f=1", buf_cnt, overflow, full); end
    total++; if (data_out !== 8'hA1 || rd_valid !== 1'b1) begin bad++; $display("FAIL simul_read: got v=%b d=%h want v=1 d=a1", rd_valid, data_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rd_valid !== 1'b1 || data_out !== e[i]) begin bad++; $display("FAIL simul_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, data_out, e[i]); end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_overflow;
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = d[i];
      tick();
    end
    data_in = 8'h99;
    tick();
    wr_en = 1'b0;
    total++; if (buf_cnt !== 3'd4 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got cnt=%0d ov=%b want cnt=4 ov=1", buf_cnt, overflow); end
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got ov=%b un=%b want 0 0", overflow, underflow); end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (data_out !== d[i]) begin bad++; $display("FAIL ovf_data[%0d]: got %h want %h", i, data_out, d[i]); end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_underflow;
    rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h55;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || buf_cnt !== 3'd1) begin bad++; $display("FAIL unf_set: got un=%b v=%b cnt=%0d want un=1 v=0 cnt=1", underflow, rd_valid, buf_cnt); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h55 || rd_valid !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL unf_read: got d=%h v=%b e=%b want d=55 v=1 e=1", data_out, rd_valid, empty); end
    clr_err = 1'b1;
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", underflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set_wins: got %b want 1", underflow); end
    tick();
    clr_err = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_reclear: got %b want 0", underflow); end
  endtask

  task automatic test_wrap_and_reset;
    logic [7:0] v;
    wr_en = 1'b1; data_in = 8'h30;
    tick();
    rd_en = 1'b1;
    for (int i = 1; i < 10; i++) begin
      v = 8'(8'h30 + i);
      data_in = v;
      tick();
      total++; if (rd_valid !== 1'b1 || data_out !== 8'(v - 8'd1) || buf_cnt !== 3'd1) begin bad++; $display("FAIL wrap[%0d]: got v=%b d=%h cnt=%0d want v=1 d=%h cnt=1", i, rd_valid, data_out, buf_cnt, 8'(v - 8'd1)); end
    end
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h39 || empty !== 1'b1) begin bad++; $display("FAIL wrap_last: got d=%h e=%b want d=39 e=1", data_out, empty); end
    wr_en = 1'b1; data_in = 8'h61;
    tick();
    data_in = 8'h62;
    tick();
    wr_en = 1'b0;
    total++; if (buf_cnt !== 3'd2) begin bad++; $display("FAIL pre_reset_cnt: got %0d want 2", buf_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (buf_cnt !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL async_reset: got cnt=%0d e=%b want cnt=0 e=1", buf_cnt, empty); end
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; data_in = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (data_out !== 8'h77 || buf_cnt !== 3'd0) begin bad++; $display("FAIL post_reset: got d=%h cnt=%0d want d=77 cnt=0", data_out, buf_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_full();
    test_overflow();
    test_underflow();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
